// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing with registered ADV7123 DAC outputs.
// Optional colour-bar generator is compiled in with VGA_TEST_PATTERN_EN.
module vga_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10
) (
  input  logic       i_clk_25M,
  input  logic       i_rst,
  input  logic [7:0] in_pixel [0:2],
  input  logic       i_pattern_sel,
  output logic [9:0] o_x_cnt,
  output logic [9:0] o_y_cnt,
  output logic       o_frame_start,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       VGA_CLK
);

  // Both totals must fit the 10-bit counters (<= 1024).
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_W  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_W  = 10'(V_SYNC);
  localparam logic [9:0] H_START   = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END     = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] V_START   = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END     = 10'(V_SYNC + V_BP + V_ACTIVE);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;

  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
    end
  end

  always_ff @(posedge i_clk_25M or posedge i_rst) begin
    if (i_rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign o_x_cnt       = x_q;
  assign o_y_cnt       = y_q;
  assign o_frame_start = (x_q == '0) && (y_q == '0);

  logic hs, vs, vis;

  assign hs  = (x_q < H_SYNC_W);
  assign vs  = (y_q < V_SYNC_W);
  assign vis = (x_q >= H_START) && (x_q < H_END) &&
               (y_q >= V_START) && (y_q < V_END);

  // in_pixel belongs to the coordinate currently on o_x_cnt/o_y_cnt.
  logic [7:0] pix_r, pix_g, pix_b;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_ACTIVE / 8);

  logic [9:0] bar_off;
  logic [2:0] bar_idx;

  always_comb begin
    bar_off = x_q - H_START;
    bar_idx = 3'(bar_off / BAR_W);
    pix_r   = in_pixel[0];
    pix_g   = in_pixel[1];
    pix_b   = in_pixel[2];
    if (i_pattern_sel) begin
      pix_r = {8{bar_idx[2]}};
      pix_g = {8{bar_idx[1]}};
      pix_b = {8{bar_idx[0]}};
    end
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = i_pattern_sel;

  always_comb begin
    pix_r = in_pixel[0];
    pix_g = in_pixel[1];
    pix_b = in_pixel[2];
  end
`endif

  logic       hs_n_q, vs_n_q, blank_n_q;
  logic [7:0] r_q, g_q, b_q;

  always_ff @(posedge i_clk_25M or posedge i_rst) begin
    if (i_rst) begin
      hs_n_q    <= 1'b1;
      vs_n_q    <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      hs_n_q    <= ~hs;
      vs_n_q    <= ~vs;
      blank_n_q <= vis;
      r_q       <= vis ? pix_r : 8'h00;
      g_q       <= vis ? pix_g : 8'h00;
      b_q       <= vis ? pix_b : 8'h00;
    end
  end

  assign VGA_HS      = hs_n_q;
  assign VGA_VS      = vs_n_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_SYNC_N  = 1'b0;
  // The DAC latches on the rising edge of the inverted clock, mid-pixel.
  assign VGA_CLK     = ~i_clk_25M;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance checked over the first 37 lines
// and a shrunken instance (17x10 raster) checked over several whole frames.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Expected pins {hs_n, vs_n, blank_n, r, g, b} for one coordinate.
  function automatic logic [26:0] model_pins(input int x, input int y, input int hsw,
                                             input int hst, input int hact, input int vsw,
                                             input int vst, input int vact,
                                             input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b, input logic sel);
    logic vis;
    logic [7:0] rr, gg, bb;
    int bar;
    vis = (x >= hst) && (x < hst + hact) && (y >= vst) && (y < vst + vact);
    rr = r; gg = g; bb = b;
    bar = 0;
`ifdef VGA_TEST_PATTERN_EN
    if (sel) begin
      bar = (x - hst) / (hact / 8);
      rr = bar[2] ? 8'hFF : 8'h00;
      gg = bar[1] ? 8'hFF : 8'h00;
      bb = bar[0] ? 8'hFF : 8'h00;
    end
`endif
    if (!vis) begin
      rr = 8'h00; gg = 8'h00; bb = 8'h00;
    end
    return {~(x < hsw), ~(y < vsw), vis, rr, gg, bb};
  endfunction

  // Full-size instance
  logic       rst_a;
  logic [7:0] pix_a [0:2];
  logic       sel_a;
  logic [9:0] x_a, y_a;
  logic       fs_a, hs_a, vs_a, bn_a, sync_a, vclk_a;
  logic [7:0] r_a, g_a, b_a;
  logic [26:0] exp_q_a[$];

  vga_timing_gen dut_a (
    .i_clk_25M(clk), .i_rst(rst_a), .in_pixel(pix_a), .i_pattern_sel(sel_a),
    .o_x_cnt(x_a), .o_y_cnt(y_a), .o_frame_start(fs_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a), .VGA_HS(hs_a), .VGA_VS(vs_a),
    .VGA_BLANK_N(bn_a), .VGA_SYNC_N(sync_a), .VGA_CLK(vclk_a)
  );

  // Shrunken instance: H 4+3+8+2=17, V 2+2+5+1=10, frame 170 cycles
  logic       rst_b;
  logic [7:0] pix_b [0:2];
  logic       sel_b;
  logic [9:0] x_b, y_b;
  logic       fs_b, hs_b, vs_b, bn_b, sync_b, vclk_b;
  logic [7:0] r_b, g_b, b_b;
  logic [26:0] exp_q_b[$];

  vga_timing_gen #(
    .H_SYNC(4), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_ACTIVE(5), .V_FP(1)
  ) dut_b (
    .i_clk_25M(clk), .i_rst(rst_b), .in_pixel(pix_b), .i_pattern_sel(sel_b),
    .o_x_cnt(x_b), .o_y_cnt(y_b), .o_frame_start(fs_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
    .VGA_BLANK_N(bn_b), .VGA_SYNC_N(sync_b), .VGA_CLK(vclk_b)
  );

  task automatic drive_a(input int y);
    if (y < 34) begin
      pix_a[0] = 8'($urandom_range(0, 255));
      pix_a[1] = 8'($urandom_range(0, 255));
      pix_a[2] = 8'($urandom_range(0, 255));
      sel_a    = 1'($urandom_range(0, 1));
    end else begin
      pix_a[0] = 8'h12; pix_a[1] = 8'h34; pix_a[2] = 8'h56;
      sel_a    = (y == 36);
    end
  endtask

  task automatic drive_b();
    pix_b[0] = 8'($urandom_range(0, 255));
    pix_b[1] = 8'($urandom_range(0, 255));
    pix_b[2] = 8'($urandom_range(0, 255));
    sel_b    = 1'($urandom_range(0, 1));
  endtask

  task automatic run_a();
    int x, y, px, py, hs_low, hs_runs;
    logic [26:0] e;
    drive_a(0);
    repeat (10) tick();
    chk("a_rst_cnt", {fs_a, y_a, x_a}, {1'b1, 20'd0});
    chk("a_rst_pins", {hs_a, vs_a, bn_a, r_a, g_a, b_a}, {3'b110, 24'h0});
    chk("a_sync_n", sync_a, 1'b0);
    chk("a_vga_clk", vclk_a, 1'b1);
    rst_a = 1'b0;
    drive_a(0);
    exp_q_a.push_back(model_pins(0, 0, 96, 144, 640, 2, 35, 480, pix_a[0], pix_a[1], pix_a[2], sel_a));
    hs_low = 0;
    hs_runs = 0;
    for (int n = 1; n <= 37 * 800; n++) begin
      tick();
      x = n % 800;  y = (n / 800) % 525;
      px = (n - 1) % 800;  py = ((n - 1) / 800) % 525;
      if (exp_q_a.size() == 0) chk("a_q_underflow", 32'd0, 32'd1);
      else begin
        e = exp_q_a.pop_front();
        chk("a_pins", {hs_a, vs_a, bn_a, r_a, g_a, b_a}, e);
      end
      chk("a_cnt", {fs_a, y_a, x_a}, {(x == 0 && y == 0), 10'(y), 10'(x)});
      if (n == 800) chk("a_y_step", {y_a, x_a}, {10'd1, 10'd0});
      if (px == 144 && py == 35) chk("a_vis_first", {bn_a, r_a, g_a, b_a}, {1'b1, 24'h123456});
      if (px == 143 && py == 35) chk("a_pre_vis_rgb", {r_a, g_a, b_a}, 24'h0);
      if (px == 784 && py == 35) chk("a_h_end", {bn_a, r_a, g_a, b_a}, 25'h0);
`ifdef VGA_TEST_PATTERN_EN
      if (px == 144 && py == 36) chk("a_bar0", {r_a, g_a, b_a}, 24'h000000);
      if (px == 224 && py == 36) chk("a_bar1", {r_a, g_a, b_a}, 24'h0000FF);
      if (px == 704 && py == 36) chk("a_bar7", {r_a, g_a, b_a}, 24'hFFFFFF);
`else
      if (px == 144 && py == 36) chk("a_sel_ignored", {r_a, g_a, b_a}, 24'h123456);
`endif
      if (!hs_a) hs_low++;
      else begin
        if (hs_low != 0 && hs_runs < 2) begin
          chk("a_hs_low_len", hs_low, 96);
          hs_runs++;
        end
        hs_low = 0;
      end
      drive_a(y);
      exp_q_a.push_back(model_pins(x, y, 96, 144, 640, 2, 35, 480, pix_a[0], pix_a[1], pix_a[2], sel_a));
    end
    chk("a_hs_runs_seen", hs_runs, 2);
  endtask

  localparam int MID_T = 2 * 170 + 6 * 17 + 10;

  task automatic run_b();
    int n, x, y, px, py, last_fs, vs_low, vs_runs, fs_seen;
    logic [26:0] e;
    drive_b();
    repeat (10) tick();
    chk("b_rst_cnt", {fs_b, y_b, x_b}, {1'b1, 20'd0});
    chk("b_rst_pins", {hs_b, vs_b, bn_b, r_b, g_b, b_b}, {3'b110, 24'h0});
    rst_b = 1'b0;
    n = 0;  last_fs = 0;  vs_low = 0;  vs_runs = 0;  fs_seen = 0;
    drive_b();
    exp_q_b.push_back(model_pins(0, 0, 4, 7, 8, 2, 4, 5, pix_b[0], pix_b[1], pix_b[2], sel_b));
    for (int t = 1; t <= 700; t++) begin
      tick();
      n++;
      x = n % 17;  y = (n / 17) % 10;
      px = (n - 1) % 17;  py = ((n - 1) / 17) % 10;
      if (exp_q_b.size() == 0) chk("b_q_underflow", 32'd0, 32'd1);
      else begin
        e = exp_q_b.pop_front();
        chk("b_pins", {hs_b, vs_b, bn_b, r_b, g_b, b_b}, e);
      end
      chk("b_cnt", {fs_b, y_b, x_b}, {(x == 0 && y == 0), 10'(y), 10'(x)});
      if (px == 7 && py == 4) chk("b_vis_first", bn_b, 1'b1);
      if (px == 15 && py == 5) chk("b_h_end", {bn_b, r_b, g_b, b_b}, 25'h0);
      if (px == 8 && py == 9) chk("b_v_end", {bn_b, r_b, g_b, b_b}, 25'h0);
      if (!vs_b) vs_low++;
      else begin
        if (vs_low != 0) begin
          chk("b_vs_low_len", vs_low, 34);
          vs_runs++;
        end
        vs_low = 0;
      end
      if (fs_b) begin
        chk("b_fs_period", t - last_fs, 170);
        last_fs = t;
        fs_seen++;
      end
      if (t == MID_T) begin
        #2 rst_b = 1'b1;
        #1;
        chk("b_async_cnt", {fs_b, y_b, x_b}, {1'b1, 20'd0});
        chk("b_async_pins", {hs_b, vs_b, bn_b, r_b, g_b, b_b}, {3'b110, 24'h0});
        tick();
        t++;
        rst_b = 1'b0;
        n = 0;  vs_low = 0;  last_fs = t;
        exp_q_b.delete();
        drive_b();
        exp_q_b.push_back(model_pins(0, 0, 4, 7, 8, 2, 4, 5, pix_b[0], pix_b[1], pix_b[2], sel_b));
      end else begin
        drive_b();
        exp_q_b.push_back(model_pins(x, y, 4, 7, 8, 2, 4, 5, pix_b[0], pix_b[1], pix_b[2], sel_b));
      end
    end
    chk("b_fs_count", fs_seen, 3);
    chk("b_vs_runs", vs_runs >= 3, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    fork
      run_a();
      run_b();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
